keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Matrix-keypad front end for the calculator; produces the key-press events that the downstream edge-detect/sync stage consumes.
- Drives one column low at a time and samples the rows through a 2-FF synchronizer.
- Debounces over whole scan frames and emits a single-cycle key_valid pulse with a row*COLS+col key code. Keypad wiring is rows-with-pull-ups, active-low columns.

Parameters:
- ROWS, 4, number of row inputs
- COLS, 4, number of column outputs
- SCAN_DIV, 1000, clk cycles each column is held low (dwell); legal minimum 4
- DEBOUNCE_SCANS, 4, consecutive identical frames required to accept a press or release; legal minimum 2
- CW, $clog2(ROWS*COLS), key_code width (derived localparam)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- row_in  in  ROWS  raw keypad rows, active-low (pressed key pulls its row low while its column is low)
- col_out  out  COLS  column strobe, one-cold, active-low
- key_code  out  CW  code of last accepted key = row*COLS + col
- key_valid  out  1  one-cycle pulse on accepted press
- key_held  out  1  level: accepted key still down

Behaviour:
- Reset (rst high at posedge clk):
  - col index = 0, col_out = all ones except bit0 = 0, dwell counter = 0.
  - Synchronizer flops = all ones.
  - key_code = 0, key_valid = 0, key_held = 0.
  - Stable counter = 0, previous frame class = NONE, frame accumulators cleared.
- Rows synchronizer: 2 flops, so row_sync lags row_in by 2 cycles.
- Scan:
  - Dwell counter counts 0..SCAN_DIV-1.
  - At count SCAN_DIV-1, sample row_sync for the current column, then advance the column index (wrap COLS-1 -> 0) and rotate col_out on the same edge.
  - Sampling at the end of the dwell guarantees at least SCAN_DIV-3 settle cycles after the column change.
- Frame accumulation:
  - For each sampled column, every row bit at 0 counts as a pressed key.
  - Track the number of pressed keys (saturating at 2) and the lowest code seen in the frame.
- Frame end: the sample of column COLS-1. A frame is COLS*SCAN_DIV cycles. At frame end:
  - Classify the frame as NONE (0 keys), SINGLE(code) (1 key) or MULTI (2 or more keys).
  - If class (and code, for SINGLE) equals the previous frame's: stable = min(stable+1, DEBOUNCE_SCANS). Otherwise stable = 1.
  - Store the class as previous, then clear the accumulators.
- Acceptance, evaluated the cycle after frame end using the updated stable count:
  - SINGLE, stable == DEBOUNCE_SCANS, key_held == 0: key_code <= code, key_held <= 1, key_valid = 1 for exactly that one cycle.
  - NONE, stable == DEBOUNCE_SCANS: key_held <= 0. key_code retains its value.
  - MULTI: no pulse, key_held unchanged, code not updated.
  - While key_held == 1, any SINGLE class (same or different key) never pulses. No rollover: all keys must be released first.
- Saturation: stable stays at DEBOUNCE_SCANS while the same class persists. A held key therefore gives exactly one pulse, with no auto-repeat.
- Latency: with a press clean from the start of frame N, key_valid asserts 1 cycle after the end of frame N+DEBOUNCE_SCANS-1.
- Reset mid-operation: everything returns to reset values on the next edge. A partial debounce is discarded and no pulse is issued. Scanning restarts at column 0 with a fresh frame.
- Mid-frame press/release: the partial frame differs from the next frame, so stable restarts at 1. No special handling is needed.
- key_valid is never asserted on two consecutive cycles.

Test Plan (ROWS=COLS=4, SCAN_DIV=4, DEBOUNCE_SCANS=3, frame = 16 cycles; the keypad model pulls a row low only while its column is low):
- Reset then idle 64 cycles -> col_out sequence 1110,1101,1011,0111 changing every 4 cycles; key_valid/key_held/key_code stay 0.
- Press row2/col1 from a frame start, hold 6 frames -> exactly one key_valid pulse, 1 cycle after the 3rd frame end (cycle 48 after press start); key_code = 9; key_held = 1; no further pulses.
- Same key toggled pressed/released on alternating frames for 8 frames -> zero key_valid pulses; key_held stays 0.
- After scenario 2, release -> key_held falls 1 cycle after the 3rd NONE frame end. Then press row3/col3 -> new pulse with key_code = 15.
- Press codes 0 and 5 together for 4 frames -> no pulse. Release 5 and keep 0 for 3 frames -> one pulse, key_code = 0. Then add 5 and later drop 0 while 5 stays held -> no new pulse until full release.
- Press code 6 for 2 frames, assert rst for 1 cycle, keep key held -> outputs 0 immediately after reset. Pulse with key_code = 6 occurs only after 3 full frames post-reset; col_out restarts at 1110.

Source files
------------

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-cold active-low column strobe, 2-FF row sync,
// frame-based debounce, single-cycle key_valid pulse with row*COLS+col code.
module keypad_scanner #(
   parameter int ROWS           = 4,
   parameter int COLS           = 4,
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4,
   localparam int CW            = $clog2(ROWS*COLS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [ROWS-1:0] row_in,
   output logic [COLS-1:0] col_out,
   output logic [CW-1:0]   key_code,
   output logic            key_valid,
   output logic            key_held
);

   localparam int CIW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int SW  = $clog2(DEBOUNCE_SCANS + 1);

   typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_t;

   logic [ROWS-1:0] sync1, row_sync;
   logic [DW-1:0]   dwell;
   logic [CIW-1:0]  col_idx;
   logic [1:0]      acc_cnt;
   logic [CW-1:0]   acc_min;
   cls_t            prev_cls;
   logic [CW-1:0]   prev_code;
   logic [SW-1:0]   stable;

   logic [1:0]      col_hits, frame_cnt;
   logic [2:0]      cnt_sum;
   logic [CW-1:0]   col_min, frame_min;
   cls_t            frame_cls;
   logic            same_cls;
   logic [SW-1:0]   stable_nxt;
   logic            sample_now, frame_end;

   assign sample_now = (dwell == DW'(SCAN_DIV - 1));
   assign frame_end  = sample_now && (col_idx == CIW'(COLS - 1));

   // Frame view including the column being sampled this cycle.
   always_comb begin
      col_hits = 2'd0;
      col_min  = '1;
      // Walk rows high-to-low so the lowest pressed row wins col_min.
      for (int r = ROWS - 1; r >= 0; r--) begin
         if (!row_sync[r]) begin
            if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
            col_min = CW'(r * COLS) + CW'(col_idx);
         end
      end
      cnt_sum   = {1'b0, acc_cnt} + {1'b0, col_hits};
      frame_cnt = (cnt_sum >= 3'd2) ? 2'd2 : cnt_sum[1:0];
      frame_min = (col_min < acc_min) ? col_min : acc_min;
      case (frame_cnt)
         2'd0:    frame_cls = CLS_NONE;
         2'd1:    frame_cls = CLS_SINGLE;
         default: frame_cls = CLS_MULTI;
      endcase
      same_cls = (frame_cls == prev_cls) &&
                 ((frame_cls != CLS_SINGLE) || (frame_min == prev_code));
      if (!same_cls)                          stable_nxt = SW'(1);
      else if (stable == SW'(DEBOUNCE_SCANS)) stable_nxt = stable;
      else                                    stable_nxt = stable + SW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1     <= '1;
         row_sync  <= '1;
         dwell     <= '0;
         col_idx   <= '0;
         col_out   <= {{(COLS-1){1'b1}}, 1'b0};
         acc_cnt   <= 2'd0;
         acc_min   <= '1;
         prev_cls  <= CLS_NONE;
         prev_code <= '0;
         stable    <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         sync1     <= row_in;
         row_sync  <= sync1;
         key_valid <= 1'b0;
         if (sample_now) begin
            dwell   <= '0;
            col_idx <= (col_idx == CIW'(COLS - 1)) ? '0 : col_idx + CIW'(1);
            col_out <= {col_out[COLS-2:0], col_out[COLS-1]};
            if (frame_end) begin
               prev_cls  <= frame_cls;
               prev_code <= frame_min;
               stable    <= stable_nxt;
               acc_cnt   <= 2'd0;
               acc_min   <= '1;
               // Acceptance is folded into the frame-end edge so code, pulse
               // and held flag become visible together in the following cycle.
               if (frame_cls == CLS_SINGLE && stable_nxt == SW'(DEBOUNCE_SCANS) && !key_held) begin
                  key_code  <= frame_min;
                  key_held  <= 1'b1;
                  key_valid <= 1'b1;
               end else if (frame_cls == CLS_NONE && stable_nxt == SW'(DEBOUNCE_SCANS)) begin
                  key_held <= 1'b0;
               end
            end else begin
               acc_cnt <= frame_cnt;
               acc_min <= frame_min;
            end
         end else begin
            dwell <= dwell + DW'(1);
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: 4x4 pad, 4-cycle dwell, 3-frame debounce.
module tb_keypad_scanner;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   logic [15:0] keys = '0;
   int asserts = 0;
   int fails   = 0;
   int pulses  = 0;
   int cyc     = 0;
   logic vld_prev = 1'b0;

   keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
      .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
      .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
   );

   always #5 clk = ~clk;

   // Keypad model: a pressed key pulls its row low only while its column is low.
   always_comb begin
      row_in = '1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
   end

   // Cycle index relative to the most recent reset edge.
   always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

   always @(negedge clk) begin
      if (key_valid) begin
         pulses++;
         asserts++;
         if (vld_prev) begin
            fails++;
            $display("FAIL key_valid_consecutive: high on two cycles in a row at cyc %0d", cyc);
         end
      end
      vld_prev = key_valid;
   end

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      logic [3:0] e;
      keys = '0;
      do_reset();
      asserts++; if (col_out !== 4'b1110) begin fails++; $display("FAIL reset_col_out: got %b expected 1110", col_out); end
      asserts++; if (key_valid !== 1'b0)  begin fails++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
      asserts++; if (key_held !== 1'b0)   begin fails++; $display("FAIL reset_key_held: got %b expected 0", key_held); end
      asserts++; if (key_code !== 4'd0)   begin fails++; $display("FAIL reset_key_code: got %0d expected 0", key_code); end
      for (int k = 1; k < 64; k++) begin
         run_to(k);
         e = 4'b1111;
         e[(k/4)%4] = 1'b0;
         asserts++;
         if (col_out !== e) begin fails++; $display("FAIL idle_col_out cyc %0d: got %b expected %b", k, col_out, e); end
      end
      run_to(64);
      asserts++; if (pulses != 0)       begin fails++; $display("FAIL idle_pulses: got %0d expected 0", pulses); end
      asserts++; if (key_held !== 1'b0) begin fails++; $display("FAIL idle_key_held: got %b expected 0", key_held); end
      asserts++; if (key_code !== 4'd0) begin fails++; $display("FAIL idle_key_code: got %0d expected 0", key_code); end
   endtask

   task automatic test_press_hold();
      int p0;
      keys = '0;
      do_reset();
      p0 = pulses;
      keys[9] = 1'b1;
      run_to(47);
      asserts++; if (key_valid !== 1'b0 || pulses != p0) begin fails++; $display("FAIL press9_early: valid %b pulses %0d expected 0/%0d", key_valid, pulses, p0); end
      asserts++; if (key_held !== 1'b0) begin fails++; $display("FAIL press9_held_early: got %b expected 0", key_held); end
      run_to(48);
      asserts++; if (key_valid !== 1'b1) begin fails++; $display("FAIL press9_pulse: got %b expected 1", key_valid); end
      asserts++; if (key_code !== 4'd9)  begin fails++; $display("FAIL press9_code: got %0d expected 9", key_code); end
      asserts++; if (key_held !== 1'b1)  begin fails++; $display("FAIL press9_held: got %b expected 1", key_held); end
      run_to(49);
      asserts++; if (key_valid !== 1'b0) begin fails++; $display("FAIL press9_pulse_width: got %b expected 0", key_valid); end
      run_to(96);
      asserts++; if (pulses != p0 + 1)  begin fails++; $display("FAIL press9_pulse_count: got %0d expected %0d", pulses - p0, 1); end
      asserts++; if (key_held !== 1'b1) begin fails++; $display("FAIL press9_held_late: got %b expected 1", key_held); end
   endtask

   // Continues directly from test_press_hold at cycle 96 (a frame start).
   task automatic test_release_next();
      int p0;
      p0 = pulses;
      keys = '0;
      run_to(143);
      asserts++; if (key_held !== 1'b1) begin fails++; $display("FAIL release_held_before: got %b expected 1", key_held); end
      run_to(144);
      asserts++; if (key_held !== 1'b0) begin fails++; $display("FAIL release_held_after: got %b expected 0", key_held); end
      asserts++; if (key_code !== 4'd9) begin fails++; $display("FAIL release_code_kept: got %0d expected 9", key_code); end
      keys[15] = 1'b1;
      run_to(191);
      asserts++; if (pulses != p0) begin fails++; $display("FAIL press15_early: pulses %0d expected %0d", pulses, p0); end
      run_to(192);
      asserts++; if (key_valid !== 1'b1) begin fails++; $display("FAIL press15_pulse: got %b expected 1", key_valid); end
      asserts++; if (key_code !== 4'd15) begin fails++; $display("FAIL press15_code: got %0d expected 15", key_code); end
      keys = '0;
   endtask

   task automatic test_toggle();
      int p0;
      keys = '0;
      do_reset();
      p0 = pulses;
      for (int f = 0; f < 8; f++) begin
         keys = (f % 2 == 0) ? 16'h0200 : 16'h0000;
         run_to((f + 1) * 16);
      end
      asserts++; if (pulses != p0)      begin fails++; $display("FAIL toggle_pulses: got %0d expected 0", pulses - p0); end
      asserts++; if (key_held !== 1'b0) begin fails++; $display("FAIL toggle_held: got %b expected 0", key_held); end
   endtask

   task automatic test_multi();
      int p0;
      keys = '0;
      do_reset();
      p0 = pulses;
      keys = 16'h0021;
      run_to(64);
      asserts++; if (pulses != p0)      begin fails++; $display("FAIL multi_pulses: got %0d expected 0", pulses - p0); end
      asserts++; if (key_held !== 1'b0) begin fails++; $display("FAIL multi_held: got %b expected 0", key_held); end
      keys = 16'h0001;
      run_to(111);
      asserts++; if (pulses != p0) begin fails++; $display("FAIL multi_to_0_early: got %0d expected 0", pulses - p0); end
      run_to(112);
      asserts++; if (key_valid !== 1'b1) begin fails++; $display("FAIL multi_to_0_pulse: got %b expected 1", key_valid); end
      asserts++; if (key_code !== 4'd0)  begin fails++; $display("FAIL multi_to_0_code: got %0d expected 0", key_code); end
      run_to(128);
      keys = 16'h0021;
      run_to(176);
      keys = 16'h0020;
      run_to(240);
      asserts++; if (pulses != p0 + 1)  begin fails++; $display("FAIL rollover_pulses: got %0d expected 1", pulses - p0); end
      asserts++; if (key_held !== 1'b1) begin fails++; $display("FAIL rollover_held: got %b expected 1", key_held); end
      asserts++; if (key_code !== 4'd0) begin fails++; $display("FAIL rollover_code: got %0d expected 0", key_code); end
      keys = '0;
      run_to(287);
      asserts++; if (key_held !== 1'b1) begin fails++; $display("FAIL rollover_release_before: got %b expected 1", key_held); end
      run_to(288);
      asserts++; if (key_held !== 1'b0) begin fails++; $display("FAIL rollover_release_after: got %b expected 0", key_held); end
   endtask

   task automatic test_reset_mid();
      int p0;
      keys = '0;
      do_reset();
      keys[6] = 1'b1;
      run_to(32);
      p0 = pulses;
      do_reset();
      asserts++; if (col_out !== 4'b1110) begin fails++; $display("FAIL midrst_col_out: got %b expected 1110", col_out); end
      asserts++; if (key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'd0) begin
         fails++; $display("FAIL midrst_outputs: valid %b held %b code %0d expected 0 0 0", key_valid, key_held, key_code);
      end
      run_to(47);
      asserts++; if (pulses != p0) begin fails++; $display("FAIL midrst_early: got %0d expected 0", pulses - p0); end
      run_to(48);
      asserts++; if (key_valid !== 1'b1) begin fails++; $display("FAIL midrst_pulse: got %b expected 1", key_valid); end
      asserts++; if (key_code !== 4'd6)  begin fails++; $display("FAIL midrst_code: got %0d expected 6", key_code); end
      keys = '0;
   endtask

   initial begin
      #1;
      test_reset();
      test_press_hold();
      test_release_next();
      test_toggle();
      test_multi();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
